// File: rtl/iir_filter_param.sv
// Direct-form-I IIR filter with programmable coefficients. One multiplier and one
// accumulator are shared over NB+NA cycles for each sample.
//   state  | meaning
//   IDLE   | ready for a sample or a coefficient write
//   MAC    | one product per cycle: b0..b(NB-1), then a1..aNA
//   OUT    | round, saturate, publish y_val, shift y history
module iir_filter_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 8,
  parameter int NB     = 3,
  parameter int NA     = 3,
  localparam int NT    = NB + NA,
  localparam int AW    = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_val,
  output logic signed [DATA_W-1:0] y_val,
  output logic                     out_valid,
  output logic                     sat,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  input  logic                     hist_clr
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(NT) + 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam int NY    = (NA > 0) ? NA : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << (FRAC_W - 1);
  localparam logic [COEF_W-1:0]       B0_RST = COEF_W'(1) << FRAC_W;
  localparam logic [AW:0]             NT_L   = (AW+1)'(NT);
  localparam logic [AW-1:0]           LAST   = AW'(NT - 1);

  logic [1:0]               r_state;
  logic [AW-1:0]            r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [COEF_W-1:0] r_coef [NT];
  logic signed [DATA_W-1:0] r_x [NB];
  logic signed [DATA_W-1:0] r_y [NY];
  logic                     r_clr_pend;

  logic signed [DATA_W-1:0] w_taps [NT];
  logic signed [DATA_W-1:0] w_opd;
  logic signed [COEF_W-1:0] w_cf;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shr;
  logic                     w_hi;
  logic                     w_lo;
  logic signed [DATA_W-1:0] w_ysat;
  logic                     w_idle;
  logic                     w_addr_ok;

  // Tap k reads x history for k < NB, y history afterwards.
  for (genvar k = 0; k < NT; k++) begin : g_tap
    if (k < NB) begin : g_x
      assign w_taps[k] = r_x[k];
    end else begin : g_y
      assign w_taps[k] = r_y[k-NB];
    end
  end

  assign w_opd      = w_taps[r_idx];
  assign w_cf       = r_coef[r_idx];
  assign w_prod     = w_cf * w_opd;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_rnd      = r_acc + RND;
  assign w_shr      = w_rnd >>> FRAC_W;
  assign w_hi       = w_shr > Y_MAX;
  assign w_lo       = w_shr < Y_MIN;
  assign w_ysat     = w_hi ? Y_MAX[DATA_W-1:0] : (w_lo ? Y_MIN[DATA_W-1:0] : w_shr[DATA_W-1:0]);
  assign w_idle     = (r_state == S_IDLE);
  assign w_addr_ok  = {1'b0, coef_addr} < NT_L;
  assign in_ready   = w_idle && !hist_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_clr_pend <= 1'b0;
      y_val      <= '0;
      out_valid  <= 1'b0;
      sat        <= 1'b0;
      coef_err   <= 1'b0;
      for (int k = 0; k < NT; k++) r_coef[k] <= '0;
      r_coef[0] <= B0_RST;
      for (int k = 0; k < NB; k++) r_x[k] <= '0;
      for (int k = 0; k < NY; k++) r_y[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
      coef_err  <= 1'b0;
      if (coef_we) begin
        if (w_idle && w_addr_ok) r_coef[coef_addr] <= coef_data;
        else coef_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (hist_clr) begin
            for (int k = 0; k < NB; k++) r_x[k] <= '0;
            for (int k = 0; k < NY; k++) r_y[k] <= '0;
            r_clr_pend <= 1'b0;
          end else if (in_valid) begin
            for (int k = NB - 1; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0]  <= x_val;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (hist_clr) r_clr_pend <= 1'b1;
          if (r_idx == LAST) r_state <= S_OUT;
          else r_idx <= r_idx + 1'b1;
        end
        S_OUT: begin
          y_val     <= w_ysat;
          out_valid <= 1'b1;
          sat       <= w_hi | w_lo;
          // A clear requested during the transaction lands here, after the result.
          if (hist_clr || r_clr_pend) begin
            for (int k = 0; k < NB; k++) r_x[k] <= '0;
            for (int k = 0; k < NY; k++) r_y[k] <= '0;
            r_clr_pend <= 1'b0;
          end else begin
            for (int k = NY - 1; k > 0; k--) r_y[k] <= r_y[k-1];
            r_y[0] <= w_ysat;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_filter_param.sv
// Bench for iir_filter_param: a sample-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_iir_filter_param;

  localparam int NB = 3;
  localparam int NA = 3;
  localparam int NT = NB + NA;
  localparam int FRAC = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_val;
  logic signed [15:0] y_val;
  logic               out_valid;
  logic               sat;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_err;
  logic               hist_clr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  longint mb [NT];
  longint mx [NB];
  longint my [NA];
  int     busy;
  bit     clr_pend;
  longint m_y, pend_y;
  bit     pend_sat, m_ov, m_sat, m_err;

  iir_filter_param #(.DATA_W(16), .COEF_W(16), .FRAC_W(FRAC), .NB(NB), .NA(NA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_val(x_val), .y_val(y_val), .out_valid(out_valid), .sat(sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err), .hist_clr(hist_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) mb[k] = 0;
    mb[0] = 256;
    for (int k = 0; k < NB; k++) mx[k] = 0;
    for (int k = 0; k < NA; k++) my[k] = 0;
    busy = 0; clr_pend = 0; m_y = 0; pend_y = 0; pend_sat = 0;
    m_ov = 0; m_sat = 0; m_err = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NB; k++) mx[k] = 0;
    for (int k = 0; k < NA; k++) my[k] = 0;
  endtask

  // y = sat(round((sum b*x + sum a*y) / 2^FRAC))
  task automatic model_compute();
    longint acc, r;
    acc = 0;
    for (int k = 0; k < NB; k++) acc += mb[k] * mx[k];
    for (int k = 0; k < NA; k++) acc += mb[NB+k] * my[k];
    r = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    pend_sat = 0;
    if (r > 32767)       begin r = 32767;  pend_sat = 1; end
    else if (r < -32768) begin r = -32768; pend_sat = 1; end
    pend_y = r;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_ov = 0; m_sat = 0; m_err = 0;
      if (busy > 0) begin
        if (coef_we) m_err = 1;
        if (hist_clr) clr_pend = 1;
        busy--;
        if (busy == 0) begin
          m_ov = 1; m_y = pend_y; m_sat = pend_sat;
          for (int k = NA - 1; k > 0; k--) my[k] = my[k-1];
          my[0] = pend_y;
          if (clr_pend) begin model_clear(); clr_pend = 0; end
        end
      end else begin
        if (coef_we) begin
          if (int'(coef_addr) < NT) mb[coef_addr] = coef_data;
          else m_err = 1;
        end
        if (hist_clr) model_clear();
        else if (in_valid) begin
          for (int k = NB - 1; k > 0; k--) mx[k] = mx[k-1];
          mx[0] = x_val;
          model_compute();
          busy = NT + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, (busy == 0 && !hist_clr) ? 1 : 0);
    check("out_valid", out_valid, m_ov);
    check("sat", sat, m_sat);
    check("coef_err", coef_err, m_err);
    check("y_val", y_val, m_y);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40 && busy != 0; i++) tick();
    if (busy != 0) check(nm, busy, 0);
  endtask

  task automatic send(input int x);
    wait_idle("send_timeout");
    in_valid = 1'b1;
    x_val = 16'(x);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_y(input string nm, input longint lit);
    wait_idle("out_timeout");
    check({nm, "_dut"}, y_val, lit);
    check({nm, "_model"}, m_y, lit);
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(val);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic pulse_clr();
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x_val = '0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; hist_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // identity passthrough after reset
    send(100);    expect_y("pass_100", 100);
    send(-32768); expect_y("pass_min", -32768);

    // third-order impulse response
    write_coef(0, 512); write_coef(1, -1536); write_coef(2, 4608);
    write_coef(3, 0);   write_coef(4, 0);     write_coef(5, -6912);
    pulse_clr();
    send(1); expect_y("imp0", 2);
    send(0); expect_y("imp1", -6);
    send(0); expect_y("imp2", 18);
    send(0); expect_y("imp3", -54);
    send(0); expect_y("imp4", 162);
    send(0); expect_y("imp5", -486);

    // history clear between samples, during MAC, and together with in_valid
    pulse_clr();
    send(5); expect_y("clr_idle", 10);
    send(7);
    hist_clr = 1'b1; tick(); hist_clr = 1'b0;
    expect_y("clr_mac_cur", -16);
    send(3); expect_y("clr_mac_next", 6);
    in_valid = 1'b1; hist_clr = 1'b1; x_val = 16'sd99;
    tick();
    in_valid = 1'b0; hist_clr = 1'b0;
    check("clr_blocks_accept", busy, 0);
    send(1); expect_y("clr_sim_next", 2);

    // saturation
    write_coef(0, 32512);
    for (int k = 1; k < NT; k++) write_coef(k, 0);
    pulse_clr();
    send(1000);  expect_y("sat_hi", 32767);
    send(-1000); expect_y("sat_lo", -32768);
    send(100);   expect_y("sat_none", 12700);

    // rounding half toward +inf
    write_coef(0, 128);
    send(3);  expect_y("rnd_p3", 2);
    send(-3); expect_y("rnd_m3", -1);
    send(2);  expect_y("rnd_p2", 1);

    // coefficient write during MAC is dropped
    send(50);
    tick();
    write_coef(0, 1000);
    expect_y("we_mac_cur", 25);
    send(50); expect_y("we_mac_kept", 25);
    write_coef(6, 5);
    write_coef(7, 5);
    tick();

    // in_valid held high: one result every NB+NA+2 cycles
    in_valid = 1'b1; x_val = 16'sd4; cnt = 0;
    repeat (24) begin
      tick();
      if (out_valid) cnt++;
    end
    in_valid = 1'b0;
    check("held_outputs", cnt, 3);
    expect_y("held_val", 2);

    // reset in the middle of a transaction
    send(10);
    tick(); tick();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    send(77); expect_y("rst_identity", 77);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
